// File: rtl/data_memory_responder_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// data_memory_responder_if : load/store request and response bundle
// Rev 1.0
// ---------------------------------------------------------------------------
interface data_memory_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_size, req_unsigned, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_size, req_unsigned, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface
`default_nettype wire

// File: rtl/data_memory_responder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// data_memory_responder : fixed-latency word RAM responder, byte/half/word.
// Option macro DMEM_ALIGN_CHECK_EN: misaligned accesses report an error.
// Rev 1.0
// ---------------------------------------------------------------------------
module data_memory_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int          LATENCY     = 2
) (
  input  wire logic clk,
  input  wire logic rst_n,
  data_memory_responder_if.slave bus
);

  localparam int c_IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int c_CNT_W = (LATENCY > 2) ? $clog2(LATENCY) : 1;

  localparam logic [1:0] c_S_IDLE = 2'd0;
  localparam logic [1:0] c_S_WAIT = 2'd1;
  localparam logic [1:0] c_S_RESP = 2'd2;

  logic [1:0]         r_state, w_next_state;
  logic [c_CNT_W-1:0] r_cnt;
  logic               w_accept, w_rsp_hs, w_enter_resp;

  logic [31:0]        w_off;
  logic               w_range_err, w_size_err, w_err;
  logic [1:0]         w_lane;
  logic [3:0]         w_be;
  logic [31:0]        w_wdata_sh;
  logic [c_IDX_W-1:0] w_idx;

  logic               r_write, r_unsigned, r_err;
  logic [1:0]         r_size, r_lane;
  logic [c_IDX_W-1:0] r_idx;
  logic [31:0]        r_rsp_rdata;
  logic               r_rsp_err;

  logic               w_src_write, w_src_unsigned, w_src_err;
  logic [1:0]         w_src_size, w_src_lane;
  logic [c_IDX_W-1:0] w_src_idx;
  logic [31:0]        w_rd_sh, w_load;

  logic [31:0]        r_mem [DEPTH_WORDS];

  assign w_accept     = bus.req_valid && (r_state == c_S_IDLE);
  assign w_rsp_hs     = bus.rsp_ready && (r_state == c_S_RESP);
  assign w_enter_resp = (r_state != c_S_RESP) && (w_next_state == c_S_RESP);

  // Request decode: range/size/alignment and byte-lane placement
  assign w_off       = bus.req_addr - BASE_ADDR;
  assign w_idx       = w_off[c_IDX_W+1:2];
  assign w_range_err = (bus.req_addr < BASE_ADDR) || ({2'b00, w_off[31:2]} >= 32'(DEPTH_WORDS));
  assign w_size_err  = (bus.req_size == 2'b11);

`ifdef DMEM_ALIGN_CHECK_EN
  logic w_align_err;
  assign w_align_err = ((bus.req_size == 2'b01) && w_off[0]) ||
                       ((bus.req_size == 2'b10) && (w_off[1:0] != 2'b00));
  assign w_err = w_range_err || w_size_err || w_align_err;
`else
  assign w_err = w_range_err || w_size_err;
`endif

  always_comb begin
    w_lane = w_off[1:0];
    w_be   = 4'b0000;
    case (bus.req_size)
      2'b00: w_be = 4'b0001 << w_lane;
      2'b01: begin
        w_lane = {w_off[1], 1'b0};
        w_be   = 4'b0011 << w_lane;
      end
      2'b10: begin
        w_lane = 2'b00;
        w_be   = 4'b1111;
      end
      default: w_be = 4'b0000;
    endcase
  end

  assign w_wdata_sh = bus.req_wdata << {w_lane, 3'b000};

  // Stores commit on the accept edge; RAM is never cleared
  always_ff @(posedge clk) begin
    if (rst_n && w_accept && bus.req_write && !w_err) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wdata_sh[8*b +: 8];
      end
    end
  end

  // A single-cycle latency enters RESP straight from IDLE, so read from live inputs then
  assign w_src_write    = (r_state == c_S_IDLE) ? bus.req_write    : r_write;
  assign w_src_unsigned = (r_state == c_S_IDLE) ? bus.req_unsigned : r_unsigned;
  assign w_src_err      = (r_state == c_S_IDLE) ? w_err            : r_err;
  assign w_src_size     = (r_state == c_S_IDLE) ? bus.req_size     : r_size;
  assign w_src_lane     = (r_state == c_S_IDLE) ? w_lane           : r_lane;
  assign w_src_idx      = (r_state == c_S_IDLE) ? w_idx            : r_idx;

  assign w_rd_sh = r_mem[w_src_idx] >> {w_src_lane, 3'b000};

  always_comb begin
    case (w_src_size)
      2'b00:   w_load = w_src_unsigned ? {24'h0, w_rd_sh[7:0]}   : {{24{w_rd_sh[7]}}, w_rd_sh[7:0]};
      2'b01:   w_load = w_src_unsigned ? {16'h0, w_rd_sh[15:0]}  : {{16{w_rd_sh[15]}}, w_rd_sh[15:0]};
      default: w_load = w_rd_sh;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_S_IDLE: if (w_accept) w_next_state = (LATENCY == 1) ? c_S_RESP : c_S_WAIT;
      c_S_WAIT: if (r_cnt == '0) w_next_state = c_S_RESP;
      c_S_RESP: if (w_rsp_hs) w_next_state = c_S_IDLE;
      default:  w_next_state = c_S_IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    case (r_state)
      c_S_IDLE: bus.req_ready = 1'b1;
      c_S_RESP: bus.rsp_valid = 1'b1;
      default:  ;
    endcase
  end

  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.rsp_err   = r_rsp_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_write     <= 1'b0;
      r_unsigned  <= 1'b0;
      r_err       <= 1'b0;
      r_size      <= 2'b00;
      r_lane      <= 2'b00;
      r_idx       <= '0;
      r_rsp_rdata <= 32'h0;
      r_rsp_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_cnt      <= c_CNT_W'(LATENCY - 1);
        r_write    <= bus.req_write;
        r_unsigned <= bus.req_unsigned;
        r_err      <= w_err;
        r_size     <= bus.req_size;
        r_lane     <= w_lane;
        r_idx      <= w_idx;
      end else if ((r_state == c_S_WAIT) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - 1'b1;
      end

      if (w_enter_resp) begin
        r_rsp_rdata <= (w_src_write || w_src_err) ? 32'h0 : w_load;
        r_rsp_err   <= w_src_err;
      end else if (w_rsp_hs) begin
        r_rsp_rdata <= 32'h0;
        r_rsp_err   <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_data_memory_responder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_data_memory_responder : randomized bench against a byte-addressed model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_data_memory_responder;

  localparam int          c_DEPTH = 1024;
  localparam logic [31:0] c_BASE  = 32'h0;
  localparam int          c_LAT   = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  data_memory_responder_if bus ();

  data_memory_responder #(
    .DEPTH_WORDS (c_DEPTH),
    .BASE_ADDR   (c_BASE),
    .LATENCY     (c_LAT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0]  m_mem [int unsigned];
  logic [31:0] g;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Byte-granular reference: memory is a sparse map of bytes
  task automatic model_access(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [1:0] size, input logic uns,
                              output logic [31:0] rdata, output logic err);
    int unsigned nb;
    logic [31:0] a, v;
    nb  = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    err = (size == 2'd3) || (addr < c_BASE) || (((addr - c_BASE) / 4) >= c_DEPTH);
`ifdef DMEM_ALIGN_CHECK_EN
    if (size != 2'd3 && (addr % nb) != 0) err = 1'b1;
`endif
    a     = addr - (addr % nb);
    rdata = 32'h0;
    if (!err) begin
      if (wr) begin
        for (int unsigned i = 0; i < nb; i++) m_mem[a + i] = wdata[8*i +: 8];
      end else begin
        v = 32'h0;
        for (int unsigned i = 0; i < nb; i++) v[8*i +: 8] = m_mem.exists(a + i) ? m_mem[a + i] : 8'h00;
        if (!uns && nb < 4 && v[8*nb-1]) v = v | ~((32'd1 << (8*nb)) - 32'd1);
        rdata = v;
      end
    end
  endtask

  task automatic run_txn(input string tag, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [1:0] size, input logic uns,
                         input int hold, output logic [31:0] got);
    logic [31:0] er;
    logic        ee;
    int          lat;
    model_access(wr, addr, wdata, size, uns, er, ee);
    @(negedge clk);
    check_value({tag, ".req_ready"}, 32'(bus.req_ready), 32'd1);
    bus.req_valid    = 1'b1;
    bus.req_write    = wr;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    @(posedge clk);
    #1;
    // scramble the request lines while busy; they must be ignored
    bus.req_valid    = 1'b0;
    bus.req_write    = 1'($urandom);
    bus.req_addr     = $urandom;
    bus.req_wdata    = $urandom;
    bus.req_size     = 2'($urandom);
    bus.req_unsigned = 1'($urandom);
    lat = 0;
    while (!bus.rsp_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check_value({tag, ".latency"}, 32'(lat), 32'(c_LAT));
    for (int h = 0; h < hold; h++) begin
      check_value({tag, ".hold_valid"}, 32'(bus.rsp_valid), 32'd1);
      check_value({tag, ".hold_rdata"}, bus.rsp_rdata, er);
      check_value({tag, ".hold_busy"}, 32'(bus.req_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    check_value({tag, ".rdata"}, bus.rsp_rdata, er);
    check_value({tag, ".err"}, 32'(bus.rsp_err), 32'(ee));
    got           = bus.rsp_rdata;
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
    check_value({tag, ".post_valid"}, 32'(bus.rsp_valid), 32'd0);
    check_value({tag, ".post_ready"}, 32'(bus.req_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] addr;
    int          r;
    rst_n            = 1'b0;
    bus.req_valid    = 1'b0;
    bus.req_write    = 1'b0;
    bus.req_addr     = 32'h0;
    bus.req_wdata    = 32'h0;
    bus.req_size     = 2'b00;
    bus.req_unsigned = 1'b0;
    bus.rsp_ready    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_value("reset.req_ready", 32'(bus.req_ready), 32'd1);
    check_value("reset.rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check_value("reset.rsp_rdata", bus.rsp_rdata, 32'h0);
    check_value("reset.rsp_err", 32'(bus.rsp_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_txn("st_word", 1'b1, 32'h10, 32'hDEADBEEF, 2'b10, 1'b0, 0, g);
    run_txn("ld_word", 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 0, g);
    check_value("ld_word.lit", g, 32'hDEADBEEF);
    run_txn("ld_b13s", 1'b0, 32'h13, 32'h0, 2'b00, 1'b0, 0, g);
    check_value("ld_b13s.lit", g, 32'hFFFFFFDE);
    run_txn("ld_b13u", 1'b0, 32'h13, 32'h0, 2'b00, 1'b1, 0, g);
    check_value("ld_b13u.lit", g, 32'h000000DE);
    run_txn("ld_h10s", 1'b0, 32'h10, 32'h0, 2'b01, 1'b0, 0, g);
    check_value("ld_h10s.lit", g, 32'hFFFFBEEF);
    run_txn("ld_h12u", 1'b0, 32'h12, 32'h0, 2'b01, 1'b1, 0, g);
    check_value("ld_h12u.lit", g, 32'h0000DEAD);
    run_txn("st_b11", 1'b1, 32'h11, 32'h00000055, 2'b00, 1'b0, 0, g);
    run_txn("ld_after_b", 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 0, g);
    check_value("ld_after_b.lit", g, 32'hDEAD55EF);
    run_txn("backpressure", 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 5, g);
    run_txn("err_range", 1'b0, c_BASE + 32'(4 * c_DEPTH), 32'h0, 2'b10, 1'b0, 0, g);
    check_value("err_range.lit", g, 32'h0);
    run_txn("err_size", 1'b0, 32'h10, 32'h0, 2'b11, 1'b0, 0, g);
    run_txn("st_mis", 1'b1, 32'h12, 32'hA5A55A5A, 2'b10, 1'b0, 0, g);
    run_txn("ld_after_mis", 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 0, g);
`ifdef DMEM_ALIGN_CHECK_EN
    check_value("ld_after_mis.lit", g, 32'hDEAD55EF);
`else
    check_value("ld_after_mis.lit", g, 32'hA5A55A5A);
`endif

    // Asynchronous reset while a load waits
    run_txn("st_20", 1'b1, 32'h20, 32'h12345678, 2'b10, 1'b0, 0, g);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = 32'h20;
    bus.req_size  = 2'b10;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    check_value("midwait.busy", 32'(bus.req_ready), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check_value("midrst.req_ready", 32'(bus.req_ready), 32'd1);
    check_value("midrst.rsp_valid", 32'(bus.rsp_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_txn("ld_after_rst", 1'b0, 32'h20, 32'h0, 2'b10, 1'b0, 0, g);
    check_value("ld_after_rst.lit", g, 32'h12345678);

    for (int w = 0; w < 16; w++) run_txn("init", 1'b1, 32'(4 * w), $urandom, 2'b10, 1'b0, 0, g);
    run_txn("init_top", 1'b1, 32'hFFC, $urandom, 2'b10, 1'b0, 0, g);

    for (int t = 0; t < 150; t++) begin
      r = $urandom_range(0, 7);
      if (r == 0)      addr = 32'h1000 + 32'($urandom_range(0, 64));
      else if (r == 1) addr = 32'hFFC + 32'($urandom_range(0, 3));
      else             addr = 32'($urandom_range(0, 63));
      run_txn("rand", 1'($urandom), addr, $urandom, 2'($urandom), 1'($urandom),
              $urandom_range(0, 3), g);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
